req_client_4ch: RTL and testbench



---
 rtl/req_client_pkg.sv | 16 +
 rtl/req_client_chan.sv | 119 +++++++++++
 rtl/req_client_4ch.sv | 39 +++
 tb/tb_req_client_4ch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/req_client_pkg.sv
// Shared types and default constants for the 4-channel request client.
package req_client_pkg;

  localparam int NCH            = 4;
  localparam int BURST_DEF      = 4;
  localparam int CNT_W_DEF      = 4;
  localparam int STARVE_LIM_DEF = 15;

  // Per-channel control state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/req_client_chan.sv
// One requester channel: job queue counter, request/burst FSM,
// starvation wait counter and sticky status flags.
module req_client_chan
  import req_client_pkg::*;
#(
  parameter int BURST      = BURST_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic job_i,
  input  logic gnt_i,
  output logic req_o,
  output logic busy_o,
  output logic done_o,
  output logic pend_ovf_o,
  output logic starve_o
);

  localparam int BEAT_W = $clog2(BURST + 1);
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  P_MAX     = {CNT_W{1'b1}};
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(STARVE_LIM);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, busy_q, done_q, ovf_q, starve_q;
  logic              done_d, ovf_d, starve_d;
  logic              burst_start, job_drop;

  // Pending-job counter: increment on token, decrement when a burst is
  // accepted; a token arriving while saturated is dropped and flagged.
  always_comb begin
    burst_start = (state_q == ST_REQ) && gnt_i;
    job_drop    = job_i && (p_q == P_MAX) && !burst_start;
    p_d         = p_q;
    if (job_i && !burst_start && !job_drop) begin
      p_d = p_q + CNT_W'(1);
    end else if (!job_i && burst_start) begin
      p_d = p_q - CNT_W'(1);
    end
    ovf_d = ovf_q | job_drop;
  end

  // Next-state logic: request while jobs are queued, count burst beats,
  // hold the beat count while pre-empted, and time starvation in REQ.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Trailing grants here are ignored; only the registered count matters.
        beat_d = '0;
        wait_d = '0;
        if (p_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (gnt_i) begin
          state_d = ST_BUSY;
          beat_d  = BEAT_W'(1);
          wait_d  = '0;
        end else if (wait_q != WAIT_LIM) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_BUSY: begin
        if (gnt_i) begin
          if (beat_q == BEAT_LAST) begin
            done_d  = 1'b1;
            beat_d  = '0;
            state_d = (p_q != '0) ? ST_REQ : ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    starve_d = starve_q | (wait_d == WAIT_LIM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      req_q    <= (state_d != ST_IDLE);
      busy_q   <= (state_d == ST_BUSY);
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      starve_q <= starve_d;
    end
  end

  assign req_o      = req_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pend_ovf_o = ovf_q;
  assign starve_o   = starve_q;

endmodule

// File: rtl/req_client_4ch.sv
// Four independent requester channels feeding a fixed-priority arbiter.
module req_client_4ch
  import req_client_pkg::*;
#(
  parameter int BURST      = BURST_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] job,
  input  logic [NCH-1:0] GNT,
  output logic [NCH-1:0] REQ,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] pend_ovf,
  output logic [NCH-1:0] starve
);

  // Each channel sees only its own job and grant bit.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    req_client_chan #(
      .BURST     (BURST),
      .CNT_W     (CNT_W),
      .STARVE_LIM(STARVE_LIM)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .job_i     (job[gi]),
      .gnt_i     (GNT[gi]),
      .req_o     (REQ[gi]),
      .busy_o    (busy[gi]),
      .done_o    (done[gi]),
      .pend_ovf_o(pend_ovf[gi]),
      .starve_o  (starve[gi])
    );
  end

endmodule

// File: tb/tb_req_client_4ch.sv
// Directed bench for req_client_4ch (BURST=4, CNT_W=4, STARVE_LIM=15).
module tb_req_client_4ch;

  logic       clk;
  logic       reset;
  logic [3:0] job;
  logic [3:0] GNT;
  logic [3:0] REQ, busy, done, pend_ovf, starve;

  int n_cmp;
  int n_bad;

  req_client_4ch dut (
    .clk     (clk),
    .reset   (reset),
    .job     (job),
    .GNT     (GNT),
    .REQ     (REQ),
    .busy    (busy),
    .done    (done),
    .pend_ovf(pend_ovf),
    .starve  (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    job   = '0;
    GNT   = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int dcnt;
    n_cmp = 0;
    n_bad = 0;

    // Reset held with all inputs active.
    reset = 1'b0;
    job   = 4'hF;
    GNT   = 4'hF;
    repeat (3) tick();
    check("rst_req", REQ, 4'h0);
    check("rst_busy", busy, 4'h0);
    check("rst_done", done, 4'h0);
    check("rst_ovf", pend_ovf, 4'h0);
    check("rst_starve", starve, 4'h0);
    job   = '0;
    GNT   = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rel_req_idle", REQ, 4'h0);

    // Single job on channel 0, grant lags REQ by one cycle.
    job = 4'b0001; tick(); job = '0;
    check("sj_req_e1", REQ, 4'h0);
    tick();
    check("sj_req_e2", REQ, 4'h1);
    tick();
    check("sj_busy_e3", busy, 4'h0);
    GNT = 4'b0001;
    tick(); check("sj_busy_b1", busy, 4'h1); check("sj_done_b1", done, 4'h0);
    tick(); check("sj_busy_b2", busy, 4'h1);
    tick(); check("sj_busy_b3", busy, 4'h1); check("sj_done_b3", done, 4'h0);
    tick();
    check("sj_done_b4", done, 4'h1);
    check("sj_busy_end", busy, 4'h0);
    check("sj_req_end", REQ, 4'h0);
    // Trailing grant while idle must be ignored.
    tick();
    check("tg_done", done, 4'h0);
    check("tg_req", REQ, 4'h0);
    check("tg_busy", busy, 4'h0);
    GNT = '0;
    repeat (3) tick();
    check("tg_req_stays0", REQ, 4'h0);

    // Pre-emption on channel 1.
    do_reset();
    job = 4'b0010; tick(); job = '0;
    tick(); check("pe_req", REQ, 4'h2);
    GNT = 4'b0010;
    tick(); tick();
    check("pe_busy_b2", busy, 4'h2);
    GNT = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pe_hold_busy", busy, 4'h2);
      check("pe_hold_done", done, 4'h0);
      check("pe_hold_req", REQ, 4'h2);
    end
    GNT = 4'b0010;
    tick(); check("pe_done_b3", done, 4'h0);
    tick(); check("pe_done_b4", done, 4'h2);
    GNT = '0;
    tick();
    check("pe_done_clr", done, 4'h0);
    check("pe_req_end", REQ, 4'h0);

    // Back-to-back jobs on channel 2 with grant held high.
    do_reset();
    GNT = 4'b0100;
    for (int t = 1; t <= 16; t++) begin
      job = (t <= 3) ? 4'b0100 : 4'b0000;
      tick();
      check($sformatf("bb_done_t%0d", t), done,
            (t == 6 || t == 10 || t == 14) ? 4'h4 : 4'h0);
      check($sformatf("bb_req_t%0d", t), REQ,
            (t >= 2 && t <= 13) ? 4'h4 : 4'h0);
    end
    GNT = '0;

    // Saturation and starvation on channel 3.
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      job = 4'b1000;
      tick();
      if (t == 15) check("sat_ovf_at15", pend_ovf, 4'h0);
    end
    job = '0;
    check("sat_ovf_at16", pend_ovf, 4'h8);
    check("stv_not_yet", starve, 4'h0);
    tick();
    check("stv_set", starve, 4'h8);
    // Drain: exactly 15 jobs were kept.
    GNT = 4'b1000;
    dcnt = 0;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (done[3]) dcnt++;
    end
    check("sat_drain_jobs", dcnt, 15);
    check("sat_req_end", REQ, 4'h0);
    check("sat_ovf_sticky", pend_ovf, 4'h8);
    check("stv_sticky", starve, 4'h8);
    GNT = '0;

    // Asynchronous reset mid-burst abandons everything.
    do_reset();
    job = 4'b0001; tick(); job = '0;
    tick();
    GNT = 4'b0001;
    tick();
    check("mr_busy", busy, 4'h1);
    #3 reset = 1'b0;
    #1;
    check("mr_req_async", REQ, 4'h0);
    check("mr_busy_async", busy, 4'h0);
    tick();
    reset = 1'b1;
    dcnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (done[0] || REQ[0]) dcnt++;
    end
    check("mr_no_activity", dcnt, 0);
    GNT = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
